data_sram_responder: RTL and testbench

- Data-side SRAM responder: the memory end of the data_sram_* interface that the EX stage drives and the MEM stage reads back.
- Services word reads with a configurable number of wait states and byte-lane writes with zero wait.
- Raises stallreq to the stall controller while a read is outstanding.
- Used as the data memory in SoC-lite simulation and as the reference responder for pipeline benches.

---
 rtl/data_sram_responder_pkg.sv | 27 ++
 rtl/data_sram_responder_if.sv | 30 +++
 rtl/data_sram_responder_bank.sv | 36 +++
 rtl/data_sram_responder.sv | 121 ++++++++++++
 tb/tb_data_sram_responder.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_sram_responder_pkg.sv
// Shared definitions for the data-side SRAM responder: FSM encodings,
// wait-counter width, default depth and the address range helper.
// Imported by the responder top; the bank is width-generic and needs none of it.

package data_sram_responder_pkg;

   // Two-state request FSM, kept as plain constants for legacy tooling.
   localparam logic [0:0] DSRAM_IDLE = 1'b0;
   localparam logic [0:0] DSRAM_WAIT = 1'b1;

   // Wait-state counter width: supports 0..15 extra read cycles.
   localparam int DSRAM_WAIT_W = 4;

   localparam int DSRAM_DEPTH_DEFAULT = 1024;

   typedef logic [DSRAM_WAIT_W-1:0] wait_cnt_t;

   // True when a byte address falls inside [base, base + depth*4).
   function automatic logic word_in_range(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input logic [31:0] depth);
      logic [31:0] off;
      off = addr - base;
      return (addr >= base) && ((off >> 2) < depth);
   endfunction

endpackage

// File: rtl/data_sram_responder_if.sv
// data_sram_* bus between the pipeline (EX drives, MEM reads back) and the
// data memory. master = pipeline side, slave = memory responder.
// stallreq travels with the bus because it belongs to the same transaction.

interface data_sram_responder_if;
   logic        data_sram_en;
   logic [3:0]  data_sram_wen;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic [31:0] data_sram_rdata;
   logic        stallreq;

   modport master (
      output data_sram_en,
      output data_sram_wen,
      output data_sram_addr,
      output data_sram_wdata,
      input  data_sram_rdata,
      input  stallreq
   );

   modport slave (
      input  data_sram_en,
      input  data_sram_wen,
      input  data_sram_addr,
      input  data_sram_wdata,
      output data_sram_rdata,
      output stallreq
   );
endinterface

// File: rtl/data_sram_responder_bank.sv
// Purpose: DEPTH x 32 data store with per-byte write enables and one registered read port.
// Latency: write lands at the posedge; read data appears the cycle after re.
// Backpressure: none; the responder decides when re/we may fire.

module dsram_bank #(
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic [3:0]        we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [31:0]       wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [31:0]       rdata
);

   logic [31:0] mem [DEPTH];

   // Byte-lane write: only lanes with their enable set are touched.
   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (we[b]) begin
            mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   // Registered read port; holds its last value while re is low.
   always_ff @(posedge clk) begin
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/data_sram_responder.sv
// Purpose: data-side SRAM responder; zero-wait byte-lane writes, word reads after WAIT_CYCLES.
// Latency: read data valid WAIT_CYCLES+1 cycles after the request is sampled; writes take effect at once.
// Backpressure: stallreq (registered) is high while a read is in WAIT; requests seen then are dropped.

module data_sram_responder
   import data_sram_responder_pkg::*;
#(
   parameter int          DEPTH       = DSRAM_DEPTH_DEFAULT,
   parameter int          ADDR_W      = 10,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          WAIT_CYCLES = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   data_sram_responder_if.slave    bus,
   output logic                    addr_err
);

   localparam wait_cnt_t WAIT_N    = wait_cnt_t'(WAIT_CYCLES);
   localparam bit        ZERO_WAIT = (WAIT_CYCLES == 0);

   logic [0:0]        state;
   wait_cnt_t         cnt;
   logic [ADDR_W-1:0] lat_idx;
   logic              lat_ok;
   logic              rd_ok;

   logic [31:0]       off;
   logic [ADDR_W-1:0] idx;
   logic              in_range;
   logic              accept;
   logic              is_wr;
   logic              is_rd;
   logic              done_rd;

   logic [3:0]        bank_we;
   logic              bank_re;
   logic [ADDR_W-1:0] bank_raddr;
   logic [31:0]       bank_rdata;

   assign off      = bus.data_sram_addr - BASE_ADDR;
   assign idx      = ADDR_W'(off >> 2);
   assign in_range = word_in_range(bus.data_sram_addr, BASE_ADDR, 32'(DEPTH));

   // Requests are only taken in IDLE and never while reset is applied.
   assign accept  = !rst && (state == DSRAM_IDLE) && bus.data_sram_en;
   assign is_wr   = accept && (bus.data_sram_wen != 4'b0000);
   assign is_rd   = accept && (bus.data_sram_wen == 4'b0000);
   assign done_rd = !rst && (state == DSRAM_WAIT) && (cnt == wait_cnt_t'(1));

   // Out-of-range writes are dropped; in-range writes go straight to the bank.
   assign bank_we    = (is_wr && in_range) ? bus.data_sram_wen : 4'b0000;
   assign bank_re    = (is_rd && ZERO_WAIT) || done_rd;
   assign bank_raddr = (state == DSRAM_WAIT) ? lat_idx : idx;

   dsram_bank #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_bank (
      .clk   (clk),
      .we    (bank_we),
      .waddr (idx),
      .wdata (bus.data_sram_wdata),
      .re    (bank_re),
      .raddr (bank_raddr),
      .rdata (bank_rdata)
   );

   // Request FSM: a read with wait states parks in WAIT until the counter runs out.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= DSRAM_IDLE;
         cnt     <= '0;
         lat_idx <= '0;
         lat_ok  <= 1'b0;
      end else begin
         case (state)
            DSRAM_IDLE: begin
               if (is_rd && !ZERO_WAIT) begin
                  state   <= DSRAM_WAIT;
                  cnt     <= WAIT_N;
                  lat_idx <= idx;
                  lat_ok  <= in_range;
               end
            end
            DSRAM_WAIT: begin
               cnt <= cnt - wait_cnt_t'(1);
               if (cnt == wait_cnt_t'(1)) begin
                  state <= DSRAM_IDLE;
               end
            end
            default: state <= DSRAM_IDLE;
         endcase
      end
   end

   // Remembers whether the last completed read was in range; out-of-range reads return 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ok <= 1'b0;
      end else if (is_rd && ZERO_WAIT) begin
         rd_ok <= in_range;
      end else if (done_rd) begin
         rd_ok <= lat_ok;
      end
   end

   // Sticky error flag for any accepted out-of-range access; cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_err <= 1'b0;
      end else if (accept && !in_range) begin
         addr_err <= 1'b1;
      end
   end

   // Bank output register is masked to 0 after reset and for out-of-range reads.
   assign bus.data_sram_rdata = rd_ok ? bank_rdata : 32'h0;
   assign bus.stallreq        = (state == DSRAM_WAIT);

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: three instances (0, 3 and 5 wait states) driven one at a time.
// The driver keeps a word-array reference model and pushes expected read data into a scoreboard;
// a negedge monitor pops it when the response is due and checks rdata, stallreq and addr_err.

module tb_data_sram_responder;

   localparam int NI    = 3;
   localparam int DEPTH = 1024;

   function automatic int wc_of(input int k);
      return (k == 0) ? 0 : ((k == 1) ? 3 : 5);
   endfunction

   logic           clk = 1'b0;
   logic [NI-1:0]  rst_v;
   logic           en      [NI];
   logic [3:0]     wen     [NI];
   logic [31:0]    addr    [NI];
   logic [31:0]    wdata   [NI];
   logic [31:0]    rdata_o [NI];
   logic           stall_o [NI];
   logic           err_o   [NI];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      data_sram_responder_if bus ();
      assign bus.data_sram_en    = en[g];
      assign bus.data_sram_wen   = wen[g];
      assign bus.data_sram_addr  = addr[g];
      assign bus.data_sram_wdata = wdata[g];
      assign rdata_o[g]          = bus.data_sram_rdata;
      assign stall_o[g]          = bus.stallreq;

      data_sram_responder #(
         .DEPTH       (DEPTH),
         .ADDR_W      (10),
         .BASE_ADDR   (32'h0000_0000),
         .WAIT_CYCLES (wc_of(g))
      ) u_dut (
         .clk      (clk),
         .rst      (rst_v[g]),
         .bus      (bus),
         .addr_err (err_o[g])
      );
   end

   // Edge counter: after posedge n, cyc == n.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference model (owned by the driver) ----------------
   typedef struct {
      int          k;
      int          due;
      logic [31:0] val;
   } sb_t;

   sb_t         sb [$];
   logic [31:0] ref_mem    [NI][DEPTH];
   int          ready_edge [NI];
   int          stall_lo   [NI];
   int          stall_hi   [NI];
   bit          err_on     [NI];
   int          err_cyc    [NI];
   bit          chk_on = 1'b0;
   bit          done   = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   // Base address is 0 in this bench, so the range is simply word index < DEPTH.
   function automatic bit in_rng(input logic [31:0] a);
      return (a >> 2) < 32'(DEPTH);
   endfunction

   // Present one request and hold it until the model says the responder is idle.
   task automatic issue(input int k, input logic [3:0] be, input logic [31:0] a,
                        input logic [31:0] d, input bit use_lit = 1'b0,
                        input logic [31:0] lit = 32'h0);
      int  e;
      int  n;
      int  idx;
      bit  ok;
      sb_t ent;
      en[k]    = 1'b1;
      wen[k]   = be;
      addr[k]  = a;
      wdata[k] = d;
      do begin
         @(posedge clk);
         #1;
         e = cyc;
      end while (e < ready_edge[k]);
      n   = wc_of(k);
      ok  = in_rng(a);
      idx = ok ? int'(a >> 2) : 0;
      if (!ok && !err_on[k]) begin
         err_on[k]  = 1'b1;
         err_cyc[k] = e;
      end
      if (be != 4'b0000) begin
         if (ok) begin
            for (int b = 0; b < 4; b++) begin
               if (be[b]) ref_mem[k][idx][8*b +: 8] = d[8*b +: 8];
            end
         end
      end else begin
         ent.k   = k;
         ent.due = e + n;
         ent.val = use_lit ? lit : (ok ? ref_mem[k][idx] : 32'h0);
         sb.push_back(ent);
         stall_lo[k]   = e;
         stall_hi[k]   = e + n - 1;
         ready_edge[k] = e + n + 1;
      end
      @(negedge clk);
      en[k]  = 1'b0;
      wen[k] = 4'b0000;
   endtask

   // Reset one instance for one edge; any read in flight is abandoned.
   task automatic do_reset(input int k);
      int  r;
      sb_t keep [$];
      sb_t ent;
      rst_v[k] = 1'b1;
      en[k]    = 1'b0;
      @(posedge clk);
      #1;
      r = cyc;
      for (int i = 0; i < sb.size(); i++) begin
         if (sb[i].k != k) keep.push_back(sb[i]);
      end
      sb      = keep;
      ent.k   = k;
      ent.due = r;
      ent.val = 32'h0;
      sb.push_back(ent);
      if (stall_hi[k] > r - 1) stall_hi[k] = r - 1;
      err_on[k]     = 1'b0;
      ready_edge[k] = r + 1;
      @(negedge clk);
      rst_v[k] = 1'b0;
   endtask

   task automatic rand_ops(input int k, input int nops);
      int          r;
      logic [31:0] a;
      logic [3:0]  be;
      for (int i = 0; i < nops; i++) begin
         r = int'($urandom_range(0, 9));
         if (r < 2) begin
            repeat (int'($urandom_range(1, 3))) @(negedge clk);
         end else begin
            if (r == 9) begin
               a = $urandom;
               if (a < 32'h1000) a = a | 32'h1000;
            end else begin
               a = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
            end
            be = 4'b0000;
            if ($urandom_range(0, 1) == 1) be = 4'($urandom_range(1, 15));
            issue(k, be, a, $urandom);
         end
      end
   endtask

   // ---------------- driver ----------------
   initial begin
      rst_v = '1;
      for (int k = 0; k < NI; k++) begin
         en[k]         = 1'b0;
         wen[k]        = 4'b0000;
         addr[k]       = 32'h0;
         wdata[k]      = 32'h0;
         ready_edge[k] = 4;
         stall_lo[k]   = 0;
         stall_hi[k]   = -1;
         err_on[k]     = 1'b0;
         err_cyc[k]    = 0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_v  = '0;
      chk_on = 1'b1;

      // Known contents for the words the random phase touches.
      for (int k = 0; k < NI; k++) begin
         for (int w = 0; w < 64; w++) issue(k, 4'hF, 32'(w) << 2, $urandom);
      end

      // No wait states: write-then-read, byte lanes, out-of-range.
      issue(0, 4'hF, 32'h10, 32'hDEAD_BEEF);
      issue(0, 4'h0, 32'h10, 32'h0, 1'b1, 32'hDEAD_BEEF);
      issue(0, 4'hF, 32'h20, 32'h1122_3344);
      issue(0, 4'b0010, 32'h20, 32'h0000_AA00);
      issue(0, 4'h0, 32'h20, 32'h0, 1'b1, 32'h1122_AA44);
      issue(0, 4'h0, 32'h1000, 32'h0, 1'b1, 32'h0);
      issue(0, 4'hF, 32'h1000, 32'hFFFF_FFFF);
      issue(0, 4'h0, 32'h0, 32'h0);
      issue(0, 4'h0, 32'h10, 32'h0, 1'b1, 32'hDEAD_BEEF);
      rand_ops(0, 80);
      do_reset(0);
      rand_ops(0, 20);

      // Three wait states: write held during WAIT lands afterwards.
      issue(1, 4'hF, 32'h10, 32'hDEAD_BEEF);
      issue(1, 4'h0, 32'h10, 32'h0, 1'b1, 32'hDEAD_BEEF);
      issue(1, 4'hF, 32'h30, 32'hCAFE_F00D);
      issue(1, 4'h0, 32'h30, 32'h0, 1'b1, 32'hCAFE_F00D);
      issue(1, 4'h0, 32'h1000, 32'h0, 1'b1, 32'h0);
      rand_ops(1, 80);

      // Five wait states: reset two cycles into the wait, then a clean read.
      issue(2, 4'hF, 32'h10, 32'hDEAD_BEEF);
      issue(2, 4'h0, 32'h10, 32'h0, 1'b1, 32'hDEAD_BEEF);
      issue(2, 4'h0, 32'h10, 32'h0, 1'b1, 32'hDEAD_BEEF);
      @(negedge clk);
      do_reset(2);
      issue(2, 4'h0, 32'h10, 32'h0, 1'b1, 32'hDEAD_BEEF);
      rand_ops(2, 80);

      repeat (10) @(negedge clk);
      done = 1'b1;
   end

   // ---------------- monitor / scoreboard ----------------
   task automatic check(input string nm, input int k, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s inst=%0d cyc=%0d got=%h expected=%h", nm, k, cyc, got, exp);
      end
   endtask

   logic [31:0] hold [NI];

   initial begin
      logic [31:0] exp_stall;
      logic [31:0] exp_err;
      for (int k = 0; k < NI; k++) hold[k] = 32'h0;
      while (!done) begin
         @(negedge clk);
         if (chk_on) begin
            for (int k = 0; k < NI; k++) begin
               while (sb.size() > 0 && sb[0].due < cyc) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL sb_missed inst=%0d cyc=%0d got=none expected_due=%0d",
                           sb[0].k, cyc, sb[0].due);
                  void'(sb.pop_front());
               end
               if (sb.size() > 0 && sb[0].k == k && sb[0].due == cyc) begin
                  hold[k] = sb[0].val;
                  void'(sb.pop_front());
                  check("rdata_resp", k, rdata_o[k], hold[k]);
               end else begin
                  check("rdata_hold", k, rdata_o[k], hold[k]);
               end
               exp_stall = (cyc >= stall_lo[k] && cyc <= stall_hi[k]) ? 32'h1 : 32'h0;
               exp_err   = (err_on[k] && cyc >= err_cyc[k]) ? 32'h1 : 32'h0;
               check("stallreq", k, {31'h0, stall_o[k]}, exp_stall);
               check("addr_err", k, {31'h0, err_o[k]}, exp_err);
            end
         end
      end
      check("sb_drained", 0, 32'(sb.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
      $fatal(1, "timeout");
   end

endmodule
